// File: rtl/uvmt_rvfi_csr_shadow_checker.sv
// RVFI CSR shadow scoreboard: per-bit shadow of NUM_CSR CSRs, read-data check.
// Optional first-error capture enabled by defining RVFI_CSR_SHADOW_FIRST_ERR_EN.
module uvmt_rvfi_csr_shadow_checker #(
    parameter int XLEN      = 32,
    parameter int NUM_CSR   = 4,
    parameter int ERR_CNT_W = 8,
    parameter int IDX_W     = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rvfi_valid_i,
    input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_rmask_i,
    input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_rdata_i,
    input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_wmask_i,
    input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_wdata_i,
    input  logic [NUM_CSR-1:0]        clear_i,
    output logic [NUM_CSR*XLEN-1:0]   shadow_o,
    output logic [NUM_CSR*XLEN-1:0]   known_o,
    output logic                      mismatch_o,
    output logic [IDX_W-1:0]          mismatch_idx_o,
    output logic [XLEN-1:0]           mismatch_bits_o,
    output logic [ERR_CNT_W-1:0]      err_cnt_o,
    output logic                      first_err_valid_o,
    output logic [IDX_W-1:0]          first_err_idx_o,
    output logic [XLEN-1:0]           first_err_exp_o,
    output logic [XLEN-1:0]           first_err_act_o
);

    logic [NUM_CSR*XLEN-1:0] shadow_q;
    logic [NUM_CSR*XLEN-1:0] known_q;
    logic [NUM_CSR*XLEN-1:0] shadow_d;
    logic [NUM_CSR*XLEN-1:0] known_d;
    logic [NUM_CSR-1:0]      fail;
    logic [XLEN-1:0]         diff_arr [NUM_CSR];

    logic                    any_fail;
    logic [IDX_W-1:0]        sel_idx;
    logic [XLEN-1:0]         sel_bits;

    logic                    mismatch_q;
    logic [IDX_W-1:0]        mismatch_idx_q;
    logic [XLEN-1:0]         mismatch_bits_q;
    logic [ERR_CNT_W-1:0]    err_cnt_q;

    for (genvar k = 0; k < NUM_CSR; k++) begin : g_ch
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] kn;
        logic [XLEN-1:0] rm;
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] wm;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] diff;
        logic [XLEN-1:0] learn;
        logic [XLEN-1:0] kn_base;
        logic            chk;

        assign sh = shadow_q[k*XLEN +: XLEN];
        assign kn = known_q[k*XLEN +: XLEN];
        assign rm = rvfi_csr_rmask_i[k*XLEN +: XLEN];
        assign rd = rvfi_csr_rdata_i[k*XLEN +: XLEN];
        assign wm = rvfi_csr_wmask_i[k*XLEN +: XLEN];
        assign wd = rvfi_csr_wdata_i[k*XLEN +: XLEN];

        // A clear suppresses both the check and read-only learning.
        assign chk     = rvfi_valid_i & ~clear_i[k];
        assign diff    = (rd ^ sh) & rm & kn;
        assign fail[k] = chk & (|diff);
        assign diff_arr[k] = diff;

        // Unknown, read, unwritten bits learn the observed read value.
        assign learn   = chk ? (rm & ~kn & ~wm) : '0;
        assign kn_base = clear_i[k] ? '0 : kn;

        assign shadow_d[k*XLEN +: XLEN] = rvfi_valid_i
            ? ((sh & ~wm & ~learn) | (wd & wm) | (rd & learn))
            : sh;
        assign known_d[k*XLEN +: XLEN] = rvfi_valid_i
            ? (kn_base | wm | learn)
            : kn_base;
    end

    assign any_fail = |fail;

`ifdef RVFI_CSR_SHADOW_FIRST_ERR_EN
    logic [XLEN-1:0] sel_exp;
    logic [XLEN-1:0] sel_act;
`endif

    // Select the lowest-index failing channel for reporting.
    always_comb begin
        sel_idx  = '0;
        sel_bits = '0;
`ifdef RVFI_CSR_SHADOW_FIRST_ERR_EN
        sel_exp  = '0;
        sel_act  = '0;
`endif
        for (int k = NUM_CSR - 1; k >= 0; k--) begin
            if (fail[k]) begin
                sel_idx  = IDX_W'(k);
                sel_bits = diff_arr[k];
`ifdef RVFI_CSR_SHADOW_FIRST_ERR_EN
                sel_exp  = shadow_q[k*XLEN +: XLEN];
                sel_act  = rvfi_csr_rdata_i[k*XLEN +: XLEN];
`endif
            end
        end
    end

    // Shadow and known-flag state for all channels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            known_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            known_q  <= known_d;
        end
    end

    // Registered mismatch report; index and bits hold between failures.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_q      <= 1'b0;
            mismatch_idx_q  <= '0;
            mismatch_bits_q <= '0;
        end else begin
            mismatch_q <= any_fail;
            if (any_fail) begin
                mismatch_idx_q  <= sel_idx;
                mismatch_bits_q <= sel_bits;
            end
        end
    end

    // Saturating count of failing cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (any_fail && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign shadow_o        = shadow_q;
    assign known_o         = known_q;
    assign mismatch_o      = mismatch_q;
    assign mismatch_idx_o  = mismatch_idx_q;
    assign mismatch_bits_o = mismatch_bits_q;
    assign err_cnt_o       = err_cnt_q;

`ifdef RVFI_CSR_SHADOW_FIRST_ERR_EN
    logic             fe_valid_q;
    logic [IDX_W-1:0] fe_idx_q;
    logic [XLEN-1:0]  fe_exp_q;
    logic [XLEN-1:0]  fe_act_q;

    // Capture the first failure after reset and freeze it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fe_valid_q <= 1'b0;
            fe_idx_q   <= '0;
            fe_exp_q   <= '0;
            fe_act_q   <= '0;
        end else if (any_fail && !fe_valid_q) begin
            fe_valid_q <= 1'b1;
            fe_idx_q   <= sel_idx;
            fe_exp_q   <= sel_exp;
            fe_act_q   <= sel_act;
        end
    end

    assign first_err_valid_o = fe_valid_q;
    assign first_err_idx_o   = fe_idx_q;
    assign first_err_exp_o   = fe_exp_q;
    assign first_err_act_o   = fe_act_q;
`else
    assign first_err_valid_o = 1'b0;
    assign first_err_idx_o   = '0;
    assign first_err_exp_o   = '0;
    assign first_err_act_o   = '0;
`endif

endmodule

// File: tb/tb_uvmt_rvfi_csr_shadow_checker.sv
// Bench for uvmt_rvfi_csr_shadow_checker: directed and random retirements
// checked against a word-level reference model of the shadow rules.
module tb_uvmt_rvfi_csr_shadow_checker;

    localparam int XL = 32;
    localparam int NC = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic            valid;
    logic [NC*XL-1:0] rmask;
    logic [NC*XL-1:0] rdata;
    logic [NC*XL-1:0] wmask;
    logic [NC*XL-1:0] wdata;
    logic [NC-1:0]   clr;

    logic [NC*XL-1:0] shadow;
    logic [NC*XL-1:0] known;
    logic            mm;
    logic [IW-1:0]   mm_idx;
    logic [XL-1:0]   mm_bits;
    logic [7:0]      cnt;
    logic            fe_v;
    logic [IW-1:0]   fe_idx;
    logic [XL-1:0]   fe_exp;
    logic [XL-1:0]   fe_act;

    logic [NC*XL-1:0] s2_shadow;
    logic [NC*XL-1:0] s2_known;
    logic            s2_mm;
    logic [IW-1:0]   s2_idx;
    logic [XL-1:0]   s2_bits;
    logic [1:0]      s2_cnt;
    logic            s2_fe_v;
    logic [IW-1:0]   s2_fe_idx;
    logic [XL-1:0]   s2_fe_exp;
    logic [XL-1:0]   s2_fe_act;

    int checks = 0;
    int errors = 0;

    uvmt_rvfi_csr_shadow_checker #(
        .XLEN(XL), .NUM_CSR(NC), .ERR_CNT_W(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid),
        .rvfi_csr_rmask_i(rmask), .rvfi_csr_rdata_i(rdata),
        .rvfi_csr_wmask_i(wmask), .rvfi_csr_wdata_i(wdata),
        .clear_i(clr), .shadow_o(shadow), .known_o(known),
        .mismatch_o(mm), .mismatch_idx_o(mm_idx),
        .mismatch_bits_o(mm_bits), .err_cnt_o(cnt),
        .first_err_valid_o(fe_v), .first_err_idx_o(fe_idx),
        .first_err_exp_o(fe_exp), .first_err_act_o(fe_act)
    );

    uvmt_rvfi_csr_shadow_checker #(
        .XLEN(XL), .NUM_CSR(NC), .ERR_CNT_W(2)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid),
        .rvfi_csr_rmask_i(rmask), .rvfi_csr_rdata_i(rdata),
        .rvfi_csr_wmask_i(wmask), .rvfi_csr_wdata_i(wdata),
        .clear_i(clr), .shadow_o(s2_shadow), .known_o(s2_known),
        .mismatch_o(s2_mm), .mismatch_idx_o(s2_idx),
        .mismatch_bits_o(s2_bits), .err_cnt_o(s2_cnt),
        .first_err_valid_o(s2_fe_v), .first_err_idx_o(s2_fe_idx),
        .first_err_exp_o(s2_fe_exp), .first_err_act_o(s2_fe_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [XL-1:0] m_sh [NC];
    logic [XL-1:0] m_kn [NC];
    bit            m_mm;
    int            m_idx;
    logic [XL-1:0] m_bits;
    int            m_cnt;
    bit            m_fev;
    int            m_feidx;
    logic [XL-1:0] m_feexp;
    logic [XL-1:0] m_feact;

    task automatic chk(input string tag, input logic [XL-1:0] obs,
                       input logic [XL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_sh[k] = '0;
            m_kn[k] = '0;
        end
        m_mm = 0; m_idx = 0; m_bits = '0; m_cnt = 0;
        m_fev = 0; m_feidx = 0; m_feexp = '0; m_feact = '0;
    endtask

    // Apply one clock edge of the spec rules to the model.
    task automatic model_step();
        bit            found;
        logic [XL-1:0] rm, rd, wm, wd, bad, learn;
        found = 0;
        for (int k = 0; k < NC; k++) begin
            rm = rmask[k*XL +: XL];
            rd = rdata[k*XL +: XL];
            if (valid && !clr[k]) begin
                bad = (rd ^ m_sh[k]) & rm & m_kn[k];
                if (bad != 0 && !found) begin
                    found = 1;
                    m_idx = k;
                    m_bits = bad;
                    if (!m_fev) begin
                        m_fev = 1;
                        m_feidx = k;
                        m_feexp = m_sh[k];
                        m_feact = rd;
                    end
                end
            end
        end
        m_mm = found;
        if (found) m_cnt++;
        for (int k = 0; k < NC; k++) begin
            rm = rmask[k*XL +: XL];
            rd = rdata[k*XL +: XL];
            wm = wmask[k*XL +: XL];
            wd = wdata[k*XL +: XL];
            learn = (valid && !clr[k]) ? (rm & ~m_kn[k] & ~wm) : '0;
            if (clr[k]) m_kn[k] = '0;
            if (valid) begin
                m_sh[k] = (m_sh[k] & ~wm) | (wd & wm);
                m_sh[k] = (m_sh[k] & ~learn) | (rd & learn);
                m_kn[k] = m_kn[k] | wm | learn;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("%s_shadow%0d", tag, k), shadow[k*XL +: XL], m_sh[k]);
            chk($sformatf("%s_known%0d", tag, k), known[k*XL +: XL], m_kn[k]);
        end
        chk({tag, "_mm"}, XL'(mm), XL'(m_mm));
        chk({tag, "_idx"}, XL'(mm_idx), XL'(m_idx));
        chk({tag, "_bits"}, mm_bits, m_bits);
        chk({tag, "_cnt"}, XL'(cnt), XL'(m_cnt > 255 ? 255 : m_cnt));
        chk({tag, "_cnt2"}, XL'(s2_cnt), XL'(m_cnt > 3 ? 3 : m_cnt));
        chk({tag, "_mm2"}, XL'(s2_mm), XL'(m_mm));
`ifdef RVFI_CSR_SHADOW_FIRST_ERR_EN
        chk({tag, "_fev"}, XL'(fe_v), XL'(m_fev));
        chk({tag, "_feidx"}, XL'(fe_idx), XL'(m_feidx));
        chk({tag, "_feexp"}, fe_exp, m_feexp);
        chk({tag, "_feact"}, fe_act, m_feact);
`else
        chk({tag, "_fev"}, XL'(fe_v), '0);
        chk({tag, "_feidx"}, XL'(fe_idx), '0);
        chk({tag, "_feexp"}, fe_exp, '0);
        chk({tag, "_feact"}, fe_act, '0);
`endif
    endtask

    task automatic idle_inputs();
        valid = 0; clr = '0;
        rmask = '0; rdata = '0; wmask = '0; wdata = '0;
    endtask

    task automatic set_ch(input int k, input logic [XL-1:0] rm,
                          input logic [XL-1:0] rd, input logic [XL-1:0] wm,
                          input logic [XL-1:0] wd);
        rmask[k*XL +: XL] = rm;
        rdata[k*XL +: XL] = rd;
        wmask[k*XL +: XL] = wm;
        wdata[k*XL +: XL] = wd;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    initial begin
        logic [XL-1:0] flip;
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;

        // Full write on channel 0
        valid = 1;
        set_ch(0, '0, '0, 32'hFFFF_FFFF, 32'h1234_5678);
        step("wr0");
        chk("wr0_const_sh", shadow[31:0], 32'h1234_5678);
        chk("wr0_const_kn", known[31:0], 32'hFFFF_FFFF);

        // Read back with one wrong bit
        valid = 1;
        set_ch(0, 32'hFFFF_FFFF, 32'h1234_5670, '0, '0);
        step("rd0");
        chk("rd0_const_bits", mm_bits, 32'h0000_0008);
        chk("rd0_const_cnt", XL'(cnt), 32'd1);

        // No retire: mismatch drops, idx/bits hold
        step("idle");

        // Channel 2 partial write then learning read
        valid = 1;
        set_ch(2, '0, '0, 32'h0000_00FF, 32'h0000_00AB);
        step("wr2");
        valid = 1;
        set_ch(2, 32'hFFFF_FFFF, 32'hFFFF_00AB, '0, '0);
        step("rd2");
        step("rd2_after");
        chk("rd2_const_sh", shadow[2*XL +: XL], 32'hFFFF_00AB);

        // Channels 1 and 3 fail together
        valid = 1;
        set_ch(1, '0, '0, 32'hFFFF_FFFF, 32'h1111_1111);
        set_ch(3, '0, '0, 32'hFFFF_FFFF, 32'h3333_3333);
        step("wr13");
        valid = 1;
        set_ch(1, 32'hFFFF_FFFF, 32'h1111_1110, '0, '0);
        set_ch(3, 32'hFFFF_FFFF, 32'h3333_3330, '0, '0);
        step("rd13");
        chk("rd13_const_idx", XL'(mm_idx), 32'd1);

        // Later error on channel 3 only; first-error capture stays
        valid = 1;
        set_ch(3, 32'h0000_00F0, 32'h0000_0000, '0, '0);
        step("rd3");

        // Clear with disagreeing read and a nibble write
        valid = 1;
        clr = 4'b0001;
        set_ch(0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_000F, 32'h0000_0005);
        step("clr0");
        chk("clr0_const_kn", known[31:0], 32'h0000_000F);

        // Clear without retire
        clr = 4'b0010;
        step("clr1");

        // Randomised retirements
        for (int i = 0; i < 300; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
            for (int k = 0; k < NC; k++) begin
                flip = ($urandom_range(0, 5) == 0) ?
                       (32'h1 << $urandom_range(0, 31)) : '0;
                case ($urandom_range(0, 2))
                    0: rmask[k*XL +: XL] = '0;
                    1: rmask[k*XL +: XL] = 32'hFFFF_FFFF;
                    default: rmask[k*XL +: XL] = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0: wmask[k*XL +: XL] = 32'hFFFF_FFFF;
                    1: wmask[k*XL +: XL] = $urandom;
                    default: wmask[k*XL +: XL] = '0;
                endcase
                wdata[k*XL +: XL] = $urandom;
                rdata[k*XL +: XL] =
                    ((m_sh[k] & m_kn[k]) | ($urandom & ~m_kn[k])) ^ flip;
            end
            step("rnd");
        end

        // Failing burst interrupted by an asynchronous reset
        for (int i = 0; i < 3; i++) begin
            valid = 1;
            set_ch(0, 32'hFFFF_FFFF, ~m_sh[0], '0, '0);
            step("burst");
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 0;

        // Saturation: five consecutive failures after reset
        valid = 1;
        set_ch(0, '0, '0, 32'hFFFF_FFFF, 32'h0);
        step("sat_wr");
        for (int i = 0; i < 5; i++) begin
            valid = 1;
            set_ch(0, 32'hFFFF_FFFF, 32'h1, '0, '0);
            step("sat");
        end
        chk("sat_const_cnt2", XL'(s2_cnt), 32'd3);
        chk("sat_const_cnt", XL'(cnt), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
